// File: rtl/led7seg_hc595_shifter_if.sv
// Word handshake between the display sequencer (master) and the 595 serializer (slave).
interface led7seg_hc595_shifter_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] dat;
  logic              vld;
  logic              rdy;

  modport master (output dat, output vld, input rdy);
  modport slave  (input dat, input vld, output rdy);
endinterface

// File: rtl/led7seg_hc595_shifter.sv
// Serializer for two cascaded 74HC595s: shifts one word MSB first on dio/sclk, then pulses rclk.
// Optional macro HC595_BLANK_EN precedes every word with a full BLANK_WORD frame (anti-ghosting).
module led7seg_hc595_shifter #(
  parameter int DATA_W      = 16,
  parameter int HALF_PERIOD = 4
`ifdef HC595_BLANK_EN
  ,
  parameter logic [DATA_W-1:0] BLANK_WORD = '0
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  led7seg_hc595_shifter_if.slave bus,
  output logic                   sclk,
  output logic                   rclk,
  output logic                   dio
);

  localparam int DIV_W = $clog2(HALF_PERIOD + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t            r_state;
  logic [DATA_W-2:0] r_shreg;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_sclk;
  logic              r_rclk;
  logic              r_dio;
  logic              r_rdy;
`ifdef HC595_BLANK_EN
  logic [DATA_W-1:0] r_hold;
  logic              r_blank;
`endif

  // The MSB goes straight to dio at accept, so the shift register only holds the bits still to send.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sclk    <= 1'b0;
      r_rclk    <= 1'b0;
      r_dio     <= 1'b0;
      r_rdy     <= 1'b0;
`ifdef HC595_BLANK_EN
      r_hold    <= '0;
      r_blank   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_sclk <= 1'b0;
          r_rclk <= 1'b0;
          if (!r_rdy) begin
            r_rdy <= 1'b1;
          end else if (bus.vld) begin
            r_rdy     <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
`ifdef HC595_BLANK_EN
            r_shreg   <= BLANK_WORD[DATA_W-2:0];
            r_dio     <= BLANK_WORD[DATA_W-1];
            r_hold    <= bus.dat;
            r_blank   <= 1'b1;
`else
            r_shreg   <= bus.dat[DATA_W-2:0];
            r_dio     <= bus.dat[DATA_W-1];
`endif
          end
        end

        SHIFT: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              if (r_bit_cnt == BIT_LAST) begin
                r_rclk  <= 1'b1;
                r_state <= LATCH;
              end else begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                r_dio     <= r_shreg[DATA_W-2];
                r_shreg   <= r_shreg << 1;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        LATCH: begin
          if (r_div_cnt == DIV_LAST) begin
            r_rclk    <= 1'b0;
            r_div_cnt <= '0;
`ifdef HC595_BLANK_EN
            if (r_blank) begin
              r_blank   <= 1'b0;
              r_shreg   <= r_hold[DATA_W-2:0];
              r_dio     <= r_hold[DATA_W-1];
              r_bit_cnt <= '0;
              r_state   <= SHIFT;
            end else begin
              r_dio   <= 1'b0;
              r_rdy   <= 1'b1;
              r_state <= IDLE;
            end
`else
            r_dio   <= 1'b0;
            r_rdy   <= 1'b1;
            r_state <= IDLE;
`endif
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign sclk    = r_sclk;
  assign rclk    = r_rclk;
  assign dio     = r_dio;
  assign bus.rdy = r_rdy;

endmodule

// File: tb/tb_led7seg_hc595_shifter.sv
// Bench for led7seg_hc595_shifter: a HALF_PERIOD=2 and a HALF_PERIOD=1 instance checked against a frame-level model.
// Defining HC595_BLANK_EN makes the model expect a blank frame before every word.
`timescale 1ns/1ps
module tb_led7seg_hc595_shifter;

  localparam int DATA_W = 16;
  localparam int MAX_FR = 256;
  localparam int NVEC   = 12;

  typedef struct {
    logic [DATA_W-1:0] dat;
    bit                disturb;
    int                inst;
    logic [DATA_W-1:0] expWord;
    int                expLat;
  } vec_t;

  logic              clk  = 1'b0;
  logic              rst  = 1'b1;
  logic [DATA_W-1:0] datA = '0;
  logic [DATA_W-1:0] datB = '0;
  logic [1:0]        vldV = '0;
  logic [1:0]        rdyV, sclkV, rclkV, dioV;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 2; g++) begin : gInst
      led7seg_hc595_shifter_if #(.DATA_W(DATA_W)) bus ();
      assign bus.dat = (g == 0) ? datA : datB;
      assign bus.vld = vldV[g];
      assign rdyV[g] = bus.rdy;
      led7seg_hc595_shifter #(.DATA_W(DATA_W), .HALF_PERIOD((g == 0) ? 2 : 1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .sclk(sclkV[g]),
        .rclk(rclkV[g]),
        .dio (dioV[g])
      );
    end
  endgenerate

  function automatic int hpOf(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic int framesPerWord();
`ifdef HC595_BLANK_EN
    return 2;
`else
    return 1;
`endif
  endfunction

  // Frame j of the frames a single handshake produces: blank frames first, the word itself last.
  function automatic logic [DATA_W-1:0] expFrame(input logic [DATA_W-1:0] w, input int j);
    if (j < framesPerWord() - 1) return '0;
    return w;
  endfunction

  function automatic int expLatency(input int g);
    return framesPerWord() * (2 * DATA_W + 1) * hpOf(g);
  endfunction

  logic [DATA_W-1:0] accum    [2];
  int                bitsSeen [2];
  logic [DATA_W-1:0] obsFrame [2][MAX_FR];
  int                obsBits  [2][MAX_FR];
  int                obsRclkW [2][MAX_FR];
  int                nFrames  [2];
  int                hiRuns   [2][MAX_FR];
  int                nHi      [2];
  int                hiLen    [2];
  int                rclkLen  [2];
  int                sclkHiLen[2];
  int                dioViol  [2];
  int                sclkViol [2];
  logic [1:0]        prevSclk = '0, prevRclk = '0, prevDio = '0, prevRdy = '0;

  // Pin-level observer: rebuilds latched words from dio at sclk rises and logs pulse/run lengths.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        accum[g]     = '0;
        bitsSeen[g]  = 0;
        rclkLen[g]   = 0;
        sclkHiLen[g] = 0;
      end else begin
        if (sclkV[g] && (dioV[g] != prevDio[g])) dioViol[g]++;
        if (sclkV[g]) begin
          sclkHiLen[g]++;
        end else if (prevSclk[g]) begin
          if (sclkHiLen[g] != hpOf(g)) sclkViol[g]++;
          sclkHiLen[g] = 0;
        end
        if (sclkV[g] && !prevSclk[g]) begin
          accum[g] = {accum[g][DATA_W-2:0], dioV[g]};
          bitsSeen[g]++;
        end
        if (rclkV[g]) begin
          if (!prevRclk[g] && nFrames[g] < MAX_FR) begin
            obsFrame[g][nFrames[g]] = accum[g];
            obsBits[g][nFrames[g]]  = bitsSeen[g];
            nFrames[g]++;
            bitsSeen[g] = 0;
          end
          rclkLen[g]++;
        end else if (prevRclk[g]) begin
          if (nFrames[g] > 0) obsRclkW[g][nFrames[g]-1] = rclkLen[g];
          rclkLen[g] = 0;
        end
        if (rdyV[g]) begin
          hiLen[g]++;
        end else if (prevRdy[g]) begin
          if (nHi[g] < MAX_FR) begin
            hiRuns[g][nHi[g]] = hiLen[g];
            nHi[g]++;
          end
          hiLen[g] = 0;
        end
      end
      prevSclk[g] = sclkV[g];
      prevRclk[g] = rclkV[g];
      prevDio[g]  = dioV[g];
      prevRdy[g]  = rdyV[g];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic waitNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic setDat(input int g, input logic [DATA_W-1:0] w);
    if (g == 0) datA = w;
    else datB = w;
  endtask

  task automatic waitRdy(input int g, input int budget);
    int n;
    n = 0;
    while (!rdyV[g] && n < budget) begin
      waitNeg();
      n++;
    end
    if (!rdyV[g]) checkOutput("rdyTimeout", 32'(rdyV[g]), 32'd1);
  endtask

  // One handshake; counts the cycles rdy stays low and optionally pokes vld/dat while busy.
  task automatic applyStimulus(input int g, input logic [DATA_W-1:0] w, input bit disturb,
                               output int lowCycles);
    waitRdy(g, 500);
    setDat(g, w);
    vldV[g] = 1'b1;
    waitNeg();
    vldV[g] = 1'b0;
    setDat(g, 16'($urandom));
    lowCycles = 0;
    while (!rdyV[g] && lowCycles < 2000) begin
      lowCycles++;
      if (disturb && lowCycles == 10) begin
        setDat(g, '0);
        vldV[g] = 1'b1;
      end else begin
        vldV[g] = 1'b0;
      end
      waitNeg();
    end
    vldV[g] = 1'b0;
  endtask

  task automatic checkFrames(input int g, input int base, input logic [DATA_W-1:0] w);
    checkOutput("frameCount", 32'(nFrames[g] - base), 32'(framesPerWord()));
    for (int j = 0; j < framesPerWord(); j++) begin
      if (base + j < nFrames[g]) begin
        checkOutput("latchedWord", 32'(obsFrame[g][base+j]), 32'(expFrame(w, j)));
        checkOutput("sclkRises", 32'(obsBits[g][base+j]), 32'(DATA_W));
        checkOutput("rclkWidth", 32'(obsRclkW[g][base+j]), 32'(hpOf(g)));
      end
    end
  endtask

  vec_t              vec  [NVEC];
  logic [7:0]        segs [8];
  logic [DATA_W-1:0] words[8];

  initial begin
    int lat, base, hiBase, k, cyc, ones;
    logic r;

    vec[0].dat = 16'hA501; vec[0].disturb = 1'b0; vec[0].inst = 0;
    vec[1].dat = 16'hFFFF; vec[1].disturb = 1'b1; vec[1].inst = 0;
    vec[2].dat = 16'h0000; vec[2].disturb = 1'b0; vec[2].inst = 0;
    vec[3].dat = 16'h8001; vec[3].disturb = 1'b0; vec[3].inst = 0;
    vec[4].dat = 16'h3C10; vec[4].disturb = 1'b0; vec[4].inst = 0;
    vec[9].dat = 16'hA501; vec[9].disturb = 1'b0; vec[9].inst = 1;
    for (int i = 5; i < 9; i++) begin
      vec[i].dat = 16'($urandom); vec[i].disturb = 1'($urandom_range(0, 1)); vec[i].inst = 0;
    end
    for (int i = 10; i < NVEC; i++) begin
      vec[i].dat = 16'($urandom); vec[i].disturb = 1'($urandom_range(0, 1)); vec[i].inst = 1;
    end
    for (int i = 0; i < NVEC; i++) begin
      vec[i].expWord = vec[i].dat;
      vec[i].expLat  = expLatency(vec[i].inst);
    end

    segs[0] = 8'h3F; segs[1] = 8'h06; segs[2] = 8'h5B; segs[3] = 8'h4F;
    segs[4] = 8'h66; segs[5] = 8'h6D; segs[6] = 8'h7D; segs[7] = 8'h07;
    for (int i = 0; i < 8; i++) words[i] = {segs[i], 8'(1 << i)};

    repeat (3) waitNeg();
    checkOutput("resetOutputs", 32'({rdyV, sclkV, rclkV, dioV}), 32'd0);
    rst = 1'b0;
    waitNeg();
    checkOutput("rdyAfterReset", 32'(rdyV), 32'h3);

    for (int i = 0; i < NVEC; i++) begin
      base = nFrames[vec[i].inst];
      applyStimulus(vec[i].inst, vec[i].dat, vec[i].disturb, lat);
      checkOutput("rdyLowCycles", 32'(lat), 32'(vec[i].expLat));
      checkFrames(vec[i].inst, base, vec[i].expWord);
    end

    // Back-to-back: vld held high across eight words, dat advanced after each accept.
    waitRdy(0, 500);
    base   = nFrames[0];
    hiBase = nHi[0];
    k      = 0;
    cyc    = 0;
    datA   = words[0];
    vldV[0] = 1'b1;
    while (k < 8 && cyc < 3000) begin
      r = rdyV[0];
      waitNeg();
      cyc++;
      if (r) begin
        k++;
        if (k < 8) datA = words[k];
        else vldV[0] = 1'b0;
      end
    end
    vldV[0] = 1'b0;
    checkOutput("burstAccepted", 32'(k), 32'd8);
    waitRdy(0, 2000);
    checkOutput("burstFrames", 32'(nFrames[0] - base), 32'(8 * framesPerWord()));
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < framesPerWord(); j++)
        if (base + i * framesPerWord() + j < nFrames[0])
          checkOutput("burstWord", 32'(obsFrame[0][base + i * framesPerWord() + j]),
                      32'(expFrame(words[i], j)));
    ones = 0;
    for (int i = hiBase + 1; i < hiBase + 8 && i < nHi[0]; i++)
      if (hiRuns[0][i] == 1) ones++;
    checkOutput("burstIdleGaps", 32'(ones), 32'd7);

    // Reset after the seventh sclk rise: no latch, clean outputs, next word unaffected.
    waitRdy(0, 500);
    datA = 16'h5AC3;
    vldV[0] = 1'b1;
    waitNeg();
    vldV[0] = 1'b0;
    cyc = 0;
    while (bitsSeen[0] < 7 && cyc < 500) begin
      waitNeg();
      cyc++;
    end
    checkOutput("reachedBit7", 32'(bitsSeen[0]), 32'd7);
    base = nFrames[0];
    rst = 1'b1;
    waitNeg();
    checkOutput("abortOutputs", 32'({sclkV[0], rclkV[0], dioV[0], rdyV[0]}), 32'd0);
    waitNeg();
    rst = 1'b0;
    waitNeg();
    checkOutput("rdyAfterAbort", 32'(rdyV[0]), 32'd1);
    repeat (5) waitNeg();
    checkOutput("noLatchOnAbort", 32'(nFrames[0] - base), 32'd0);
    base = nFrames[0];
    applyStimulus(0, 16'h1234, 1'b0, lat);
    checkOutput("rdyLowAfterAbort", 32'(lat), 32'(expLatency(0)));
    checkFrames(0, base, 16'h1234);

    checkOutput("dioStableA", 32'(dioViol[0]), 32'd0);
    checkOutput("dioStableB", 32'(dioViol[1]), 32'd0);
    checkOutput("sclkHighA", 32'(sclkViol[0]), 32'd0);
    checkOutput("sclkHighB", 32'(sclkViol[1]), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
